// File: rtl/regf_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// regf_fifo_ctrl
//
// Circular-buffer controller that runs an external one-write/one-read
// register file as a FIFO. It owns the write/read pointers, gates the
// regfile enables, tracks occupancy and flags the cycle in which the
// regfile read data is valid. Read data goes straight from the regfile
// to the consumer; this block never sees it.
//
// Build option:
//   REGF_FIFO_ERR_EN  when defined, builds sticky overflow/underflow flags
//                     (ovf/udf) cleared by err_clr. When undefined, ovf/udf
//                     are tied low and err_clr is ignored. The ports exist
//                     in both builds.
//
// Parameters:
//   ADDR_WIDTH   regfile address width, FIFO depth = 2**ADDR_WIDTH
//   DATA_WIDTH   word width passed through to the regfile write data
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   wr_en        producer push request
//   wr_data      word to push
//   full         level == DEPTH
//   rd_en        consumer pop request
//   rd_valid     regfile read data valid this cycle (registered)
//   empty        level == 0
//   level        occupancy, 0..DEPTH
//   regf_addr_w  regfile write address (write pointer)
//   regf_data_w  regfile write data (equals wr_data)
//   regf_we      regfile write enable
//   regf_addr_r  regfile read address (read pointer)
//   regf_rd      regfile read enable
//   err_clr      clears the sticky error flags
//   ovf          sticky: push attempted while full
//   udf          sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module regf_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH-1:0] regf_addr_w,
  output logic [DATA_WIDTH-1:0] regf_data_w,
  output logic                  regf_we,
  output logic [ADDR_WIDTH-1:0] regf_addr_r,
  output logic                  regf_rd,
  input  logic                  err_clr,
  output logic                  ovf,
  output logic                  udf
);

  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wptr_q,  wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q,  rptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  rd_valid_q, rd_valid_d;

  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic rd_acc;

  // Status decoded from the registered occupancy only, so accept decisions
  // never depend on same-cycle requests from the other side.
  assign full_w  = (level_q == LEVEL_FULL);
  assign empty_w = (level_q == '0);

  // Enables are held off while reset is asserted so the regfile cannot be
  // written or read during an asynchronous reset window.
  assign wr_acc = wr_en & ~full_w  & ~rst;
  assign rd_acc = rd_en & ~empty_w & ~rst;

  // Next-state logic. A read accepted at level >= 1 and a write accepted at
  // level <= DEPTH-1 always target different addresses, so no conflict
  // handling is needed between the two pointers.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    rd_valid_d = rd_acc;

    if (wr_acc) begin
      wptr_d = wptr_q + ADDR_WIDTH'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + ADDR_WIDTH'(1);
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
      2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef REGF_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A set in the same cycle as a clear wins: the new event must not be lost.
  always_comb begin
    ovf_d = (ovf_q & ~err_clr) | (wr_en & full_w);
    udf_d = (udf_q & ~err_clr) | (rd_en & empty_w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign ovf            = 1'b0;
  assign udf            = 1'b0;
`endif

  assign full        = full_w;
  assign empty       = empty_w;
  assign level       = level_q;
  assign rd_valid    = rd_valid_q;
  assign regf_addr_w = wptr_q;
  assign regf_data_w = wr_data;
  assign regf_we     = wr_acc;
  assign regf_addr_r = rptr_q;
  assign regf_rd     = rd_acc;

endmodule

// File: tb/tb_regf_fifo_ctrl.sv
module tb_regf_fifo_ctrl;

  localparam int AW = 3;
  localparam int DW = 8;

`ifdef REGF_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          rd_en;
  logic          rd_valid;
  logic          empty;
  logic [AW:0]   level;
  logic [AW-1:0] regf_addr_w;
  logic [DW-1:0] regf_data_w;
  logic          regf_we;
  logic [AW-1:0] regf_addr_r;
  logic          regf_rd;
  logic          err_clr;
  logic          ovf;
  logic          udf;

  regf_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .level       (level),
    .regf_addr_w (regf_addr_w),
    .regf_data_w (regf_data_w),
    .regf_we     (regf_we),
    .regf_addr_r (regf_addr_r),
    .regf_rd     (regf_rd),
    .err_clr     (err_clr),
    .ovf         (ovf),
    .udf         (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural one-write/one-read regfile driven by the controller.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_m;

  always @(posedge clk) begin
    if (regf_we) mem[regf_addr_w] <= regf_data_w;
    if (regf_rd) rdata_m <= mem[regf_addr_r];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid read cycle consumes the oldest expected word.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1 data 0x%0h expected no read at %0t", rdata_m, $time);
      end else begin
        check("rd_data", rdata_m, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + DW'(i);
      exp_q.push_back(wr_data);
      cyc();
    end
    wr_en = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) cyc();
    rd_en = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;

    // Reset state; enables must stay low even with requests present.
    #2;
    wr_en = 1'b1; rd_en = 1'b1;
    #1;
    check("rst_we", regf_we, 0);
    check("rst_rd", regf_rd, 0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_udf", udf, 0);
    check("rst_addr_w", regf_addr_w, 0);
    check("rst_addr_r", regf_addr_r, 0);
    wr_en = 1'b0; rd_en = 1'b0;
    cyc();
    rst = 1'b0;

    // Fill: 8 pushes of 0x10..0x17.
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(i);
      #1;
      check("fill_addr_w", regf_addr_w, i);
      check("fill_we", regf_we, 1);
      check("fill_level", level, i);
      exp_q.push_back(wr_data);
      cyc();
    end
    wr_en = 1'b0;
    #1;
    check("fill_full", full, 1);
    check("fill_level8", level, 8);
    check("fill_addr_wrap", regf_addr_w, 0);
    check("fill_empty", empty, 0);

    // Drain: 8 back-to-back pops.
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_addr_r", regf_addr_r, i);
      check("drain_rd", regf_rd, 1);
      check("drain_rd_valid", rd_valid, (i > 0) ? 1 : 0);
      check("drain_level", level, 8 - i);
      cyc();
    end
    rd_en = 1'b0;
    #1;
    check("drain_last_valid", rd_valid, 1);
    check("drain_empty", empty, 1);
    check("drain_level0", level, 0);
    cyc();
    check("drain_valid_off", rd_valid, 0);

    // Pointer wrap across address 7 -> 0.
    push_n(5, 8'h20);
    pop_n(5);
    push_n(6, 8'h30);
    #1;
    check("wrap_addr_w", regf_addr_w, 3);
    check("wrap_level6", level, 6);
    pop_n(6);
    check("wrap_level0", level, 0);
    check("wrap_addr_r", regf_addr_r, 3);

    // Full with simultaneous push and pop: read wins.
    push_n(8, 8'h40);
    #1;
    check("both_full", full, 1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
    #1;
    check("both_full_we", regf_we, 0);
    check("both_full_rd", regf_rd, 1);
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    #1;
    check("both_full_level", level, 7);
    pop_n(7);
    check("both_drain_level", level, 0);

    // Empty with simultaneous push and pop: write wins, no bypass.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
    #1;
    check("both_empty_we", regf_we, 1);
    check("both_empty_rd", regf_rd, 0);
    exp_q.push_back(8'h55);
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    #1;
    check("both_empty_level", level, 1);
    check("both_empty_nobypass", rd_valid, 0);
    pop_n(1);

    // Sticky error flags.
    rd_en = 1'b1;
    #1;
    check("udf_before", udf, 0);
    cyc();
    rd_en = 1'b0;
    #1;
    check("udf_set", udf, ERR_EN);
    push_n(8, 8'h60);
    wr_en = 1'b1; wr_data = 8'hAA;
    #1;
    check("ovf_before", ovf, 0);
    cyc();
    wr_en = 1'b0;
    #1;
    check("ovf_set", ovf, ERR_EN);
    check("ovf_level", level, 8);
    cyc(); cyc();
    check("ovf_hold", ovf, ERR_EN);
    check("udf_hold", udf, ERR_EN);
    err_clr = 1'b1;
    #1;
    check("clr_same_cycle", ovf, ERR_EN);
    cyc();
    err_clr = 1'b0;
    #1;
    check("clr_ovf", ovf, 0);
    check("clr_udf", udf, 0);
    wr_en = 1'b1; err_clr = 1'b1; wr_data = 8'hBB;
    cyc();
    wr_en = 1'b0; err_clr = 1'b0;
    #1;
    check("set_wins", ovf, ERR_EN);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #1;
    check("clr_again", ovf, 0);

    // Reset mid-burst with a pop in flight.
    pop_n(4);
    check("pre_rst_level", level, 4);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("inflight_valid", rd_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_addr_w", regf_addr_w, 0);
    check("mid_rst_addr_r", regf_addr_r, 0);
    cyc();
    rst = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77;
    #1;
    check("post_rst_addr_w", regf_addr_w, 0);
    check("post_rst_we", regf_we, 1);
    exp_q.push_back(8'h77);
    cyc();
    wr_en = 1'b0;
    pop_n(1);
    cyc();
    check("drain_complete", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
